sram_bus_arbiter: RTL and testbench

Arbitrates the core's instruction-fetch and data-memory SRAM-style ports onto one shared request/handshake bus: bus_req, then bus_addr_ok, then bus_data_ok. It generates per-channel stall signals back into the pipeline and sits between the mips core boundary and the external memory/AXI bridge. It generalises the fixed single-cycle memory ports to a parametrised address/data width, with selectable priority and a watchdog timeout.

---
 rtl/sram_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the instruction-fetch and data SRAM-style ports onto one shared
// req / addr_ok / data_ok bus, with one outstanding transaction and a watchdog.
module sram_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DATA_FIRST = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_data_ok,
  output logic                bus_err
);

  localparam int SEL_W = DATA_W / 8;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic WD_EN  = (TIMEOUT > 0);
  localparam logic DFIRST = (DATA_FIRST != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_wr_q, bus_wr_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              inst_pend, data_pend, pick_data;
  logic              issue, complete, timeout, finish;
  logic [DATA_W-1:0] result;

  // A channel whose done flag is still high is not re-selected, so a held
  // request is never issued twice.
  always_comb begin
    inst_pend = inst_req & ~inst_done_q;
    data_pend = data_req & ~data_done_q;
    pick_data = data_pend & (DFIRST | ~inst_pend);
    issue     = (state_q == S_IDLE) & (inst_pend | data_pend);
    complete  = ((state_q == S_ADDR) & bus_addr_ok & bus_data_ok) |
                ((state_q == S_DATA) & bus_data_ok);
    timeout   = WD_EN & (state_q != S_IDLE) & ~complete &
                ((wdog_q + 1'b1) == WD_LIMIT);
    finish    = complete | timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (issue) state_d = S_ADDR;
      S_ADDR: begin
        if (finish)           state_d = S_IDLE;
        else if (bus_addr_ok) state_d = S_DATA;
      end
      S_DATA: if (finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_err_d    = bus_err_q;
    wdog_d       = '0;
    result       = '0;

    if (issue) begin
      bus_req_d = 1'b1;
      owner_d   = pick_data;
      if (pick_data) begin
        bus_wr_d    = data_wr;
        bus_sel_d   = data_sel;
        bus_addr_d  = data_addr;
        bus_wdata_d = data_wdata;
      end else begin
        bus_wr_d    = 1'b0;
        bus_sel_d   = '1;
        bus_addr_d  = inst_addr;
        bus_wdata_d = '0;
      end
    end

    if ((state_q == S_ADDR) & bus_addr_ok) bus_req_d = 1'b0;

    if (WD_EN & (state_q != S_IDLE) & ~finish) wdog_d = wdog_q + 1'b1;

    if (timeout) begin
      bus_req_d = 1'b0;
      bus_err_d = 1'b1;
    end

    // A withdrawn request still lets the bus finish, but its result is dropped.
    if (finish) begin
      result = (complete & ~bus_wr_q) ? bus_rdata : '0;
      if (owner_q & data_req) begin
        data_done_d  = 1'b1;
        data_rdata_d = result;
      end
      if (~owner_q & inst_req) begin
        inst_done_d  = 1'b1;
        inst_rdata_d = result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_err_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      owner_q      <= owner_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_err_q    <= bus_err_d;
      wdog_q       <= wdog_d;
    end
  end

  // Stalls depend only on core requests and registered done flags.
  always_comb begin
    inst_stall = inst_req & ~inst_done_q;
    data_stall = data_req & ~data_done_q;
    inst_rdata = inst_rdata_q;
    data_rdata = data_rdata_q;
    bus_req    = bus_req_q;
    bus_wr     = bus_wr_q;
    bus_sel    = bus_sel_q;
    bus_addr   = bus_addr_q;
    bus_wdata  = bus_wdata_q;
    bus_err    = bus_err_q;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: table-driven single transactions with a result
// scoreboard, plus hand-written arbitration, flush, watchdog and reset sequences.
module tb_sram_bus_arbiter;

  logic        clk, rst;
  logic        inst_req, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_stall;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, bus_err;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  sram_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DATA_FIRST(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_rdata(bus_rdata),
    .bus_data_ok(bus_data_ok), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_data;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic [7:0]  addr_wait;
    logic [7:0]  data_wait;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    logic got;
    logic stall;
    logic [31:0] act;
    if (v.is_data) begin
      data_req = 1'b1; data_wr = v.wr; data_sel = v.sel;
      data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    e.is_data = v.is_data;
    e.rdata   = v.exp_rdata;
    sb.push_back(e);

    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_req) begin
        got = 1'b1;
        break;
      end
    end
    check("txn_req_seen", got, 1'b1);
    if (!got) begin
      void'(sb.pop_front());
      inst_req = 1'b0; data_req = 1'b0;
      tick();
      return;
    end

    for (int i = 0; i <= int'(v.addr_wait); i++) begin
      if (i > 0) tick();
      check("txn_bus_req_held", bus_req, 1'b1);
      check("txn_bus_addr", bus_addr, v.addr);
      check("txn_bus_sel", bus_sel, v.exp_sel);
      check("txn_bus_wr", bus_wr, v.is_data & v.wr);
      if (v.wr) check("txn_bus_wdata", bus_wdata, v.wdata);
      stall = v.is_data ? data_stall : inst_stall;
      check("txn_stall_busy", stall, 1'b1);
    end

    bus_addr_ok = 1'b1;
    if (v.data_wait == 0) begin
      bus_data_ok = 1'b1;
      bus_rdata   = v.resp;
    end
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (v.data_wait != 0) begin
      check("txn_req_dropped", bus_req, 1'b0);
      for (int j = 1; j < int'(v.data_wait); j++) tick();
      bus_data_ok = 1'b1;
      bus_rdata   = v.resp;
      tick();
      bus_data_ok = 1'b0;
    end

    stall = v.is_data ? data_stall : inst_stall;
    check("txn_stall_done", stall, 1'b0);
    if (sb.size() == 0) begin
      check("txn_sb_empty", 1'b1, 1'b0);
    end else begin
      e   = sb.pop_front();
      act = e.is_data ? data_rdata : inst_rdata;
      check("txn_rdata", act, e.rdata);
    end

    tick();
    check("txn_no_dup_issue", bus_req, 1'b0);
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h24080001, 8'd1, 8'd2, 4'hF, 32'h24080001};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h80001002, 32'h1234ABCD, 32'hDEADBEEF, 8'd2, 8'd1, 4'h3, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h80000010, 32'h0,        32'hCAFEF00D, 8'd0, 8'd0, 4'hF, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h00400000, 32'h0,        32'h11112222, 8'd0, 8'd3, 4'hF, 32'h11112222};
    vecs[4] = '{1'b1, 1'b0, 4'hC, 32'h80000404, 32'h0,        32'h87654321, 8'd3, 8'd1, 4'hC, 32'h87654321};

    tick();
    tick();
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_sel", bus_sel, 4'h0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_txn(vecs[k]);

    // Simultaneous fetch and load on a zero-wait bus: data goes first.
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'hF; data_addr = 32'h80000010;
    tick();
    check("sim_first_req", bus_req, 1'b1);
    check("sim_first_addr", bus_addr, 32'h80000010);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hD0D0D0D1;
    tick();
    check("sim_data_stall_low", data_stall, 1'b0);
    check("sim_data_rdata", data_rdata, 32'hD0D0D0D1);
    check("sim_inst_stall_high", inst_stall, 1'b1);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    data_req = 1'b0;
    tick();
    check("sim_second_req", bus_req, 1'b1);
    check("sim_second_addr", bus_addr, 32'hBFC00100);
    check("sim_second_sel", bus_sel, 4'hF);
    check("sim_data_stall_stays_low", data_stall, 1'b0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h13579BDF;
    tick();
    check("sim_inst_stall_low", inst_stall, 1'b0);
    check("sim_inst_rdata", inst_rdata, 32'h13579BDF);
    check("sim_req_low", bus_req, 1'b0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    tick();
    check("sim_no_third_req", bus_req, 1'b0);
    inst_req = 1'b0;
    tick();

    // Fetch withdrawn while in DATA: result discarded, next fetch normal.
    inst_req = 1'b1; inst_addr = 32'h00400100;
    tick();
    check("flush_req", bus_req, 1'b1);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    inst_req = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h99999999;
    tick();
    bus_data_ok = 1'b0;
    check("flush_rdata_kept", inst_rdata, 32'h13579BDF);
    inst_req = 1'b1; inst_addr = 32'h00400200;
    #1;
    check("flush_no_done", inst_stall, 1'b1);
    tick();
    check("flush_next_req", bus_req, 1'b1);
    check("flush_next_addr", bus_addr, 32'h00400200);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    check("flush_next_stall", inst_stall, 1'b0);
    check("flush_next_rdata", inst_rdata, 32'h55AA55AA);
    inst_req = 1'b0;
    tick();

    // Silent bus: watchdog fires after 8 busy cycles.
    inst_req = 1'b1; inst_addr = 32'hBFC00200;
    tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_req) break;
      cnt++;
      check("wd_err_not_yet", bus_err, 1'b0);
      tick();
    end
    check("wd_busy_cycles", cnt, 8);
    check("wd_bus_err", bus_err, 1'b1);
    check("wd_done_stall", inst_stall, 1'b0);
    check("wd_rdata_zero", inst_rdata, 32'h0);
    tick();
    check("wd_no_reissue", bus_req, 1'b0);
    inst_req = 1'b0;
    tick();
    check("wd_err_sticky", bus_err, 1'b1);

    // Asynchronous reset in the middle of an ADDR phase.
    data_req = 1'b1; data_wr = 1'b1; data_sel = 4'hF;
    data_addr = 32'h80002000; data_wdata = 32'hA5A5A5A5;
    tick();
    check("ar_req_up", bus_req, 1'b1);
    #2;
    rst = 1'b0;
    data_req = 1'b0;
    #1;
    check("ar_bus_req", bus_req, 1'b0);
    check("ar_bus_wr", bus_wr, 1'b0);
    check("ar_bus_sel", bus_sel, 4'h0);
    check("ar_bus_addr", bus_addr, 32'h0);
    check("ar_bus_wdata", bus_wdata, 32'h0);
    check("ar_bus_err", bus_err, 1'b0);
    check("ar_inst_rdata", inst_rdata, 32'h0);
    check("ar_data_rdata", data_rdata, 32'h0);
    check("ar_data_stall", data_stall, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("ar_idle_after", bus_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
